mem_port_arbiter: RTL and testbench

- Shares one memory port between instruction fetch (IF, driven by the PC) and the data-access path (MEM stage loads/stores).
- Sequences each access as a registered request/acknowledge transaction with a slave that may insert wait states.
- Returns read data and a one-cycle ready pulse to the winning requester.
- Raises stall requests that the pipeline controller combines with the existing bubble/stall logic.

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_port_arbiter_wdog.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: state encodings, default widths and byte-select constant
// shared by the memory-port arbiter and its watchdog.
package mem_port_arbiter_pkg;

   localparam int unsigned ARB_ADDR_W    = 32;
   localparam int unsigned ARB_DATA_W    = 32;
   localparam int unsigned ARB_MAX_SEL_W = 64;

   // Wide enough for any supported DATA_W; users truncate to their own byte-select width.
   localparam logic [ARB_MAX_SEL_W-1:0] ARB_SEL_ALL = '1;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_IF_ACC = 2'd1,
      ARB_DM_ACC = 2'd2,
      ARB_DONE   = 2'd3
   } arb_state_e;

   function automatic logic arb_is_acc(input arb_state_e s);
      return (s == ARB_IF_ACC) || (s == ARB_DM_ACC);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_wdog.sv
// mem_port_arbiter_wdog: wait-state counter for the arbiter, used only when ARB_TIMEOUT_EN
// is defined. Counts enabled cycles since the last clear; expired stays high until cleared.
module mem_port_arbiter_wdog #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             expired_q, expired_d;

   // Counter stops once the limit is hit so it cannot wrap while the abort is in flight.
   always_comb begin
      cnt_d     = cnt_q;
      expired_d = expired_q;
      if (clr) begin
         cnt_d     = '0;
         expired_d = 1'b0;
      end else if (en && !expired_q) begin
         cnt_d     = cnt_q + CNT_W'(1);
         expired_d = (cnt_d == CNT_W'(TIMEOUT));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         expired_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         expired_q <= expired_d;
      end
   end

   assign expired = expired_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus port between instruction fetch and data access.
// Defining ARB_TIMEOUT_EN adds a wait-state watchdog and the sticky bus_err output.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W  = ARB_ADDR_W,
   parameter int unsigned DATA_W  = ARB_DATA_W
`ifdef ARB_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT = 255
`endif
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_ready,
   input  logic                dm_req,
   input  logic                dm_we,
   input  logic [DATA_W/8-1:0] dm_sel,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [DATA_W-1:0]   dm_wdata,
   output logic [DATA_W-1:0]   dm_rdata,
   output logic                dm_ready,
   output logic                bus_req,
   output logic                bus_we,
   output logic [DATA_W/8-1:0] bus_sel,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W-1:0]   bus_wdata,
   input  logic [DATA_W-1:0]   bus_rdata,
   input  logic                bus_ack,
   output logic                stallreq_if,
   output logic                stallreq_mem
`ifdef ARB_TIMEOUT_EN
   ,
   output logic                bus_err
`endif
);

   localparam int unsigned SEL_W = DATA_W / 8;

   arb_state_e        state_q, state_d;
   logic              last_dm_q, last_dm_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_we_q, bus_we_d;
   logic [SEL_W-1:0]  bus_sel_q, bus_sel_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              if_ready_q, if_ready_d;
   logic              dm_ready_q, dm_ready_d;

`ifdef ARB_TIMEOUT_EN
   logic wd_expired;
   logic bus_err_q, bus_err_d;

   mem_port_arbiter_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk     (clk),
      .rst     (rst),
      .clr     (state_q == ARB_IDLE),
      .en      (arb_is_acc(state_q) && !bus_ack),
      .expired (wd_expired)
   );

   assign bus_err = bus_err_q;
`endif

   // Next-state and registered-output logic; ready pulses default low so they last one cycle.
   always_comb begin
      state_d     = state_q;
      last_dm_d   = last_dm_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_sel_d   = bus_sel_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      if_ready_d  = 1'b0;
      dm_ready_d  = 1'b0;
`ifdef ARB_TIMEOUT_EN
      bus_err_d   = bus_err_q;
`endif

      unique case (state_q)
         ARB_IDLE: begin
            // Under contention the data path wins unless it won the previous grant.
            if (dm_req && (!if_req || !last_dm_q)) begin
               bus_req_d   = 1'b1;
               bus_we_d    = dm_we;
               bus_sel_d   = dm_sel;
               bus_addr_d  = dm_addr;
               bus_wdata_d = dm_wdata;
               last_dm_d   = 1'b1;
               state_d     = ARB_DM_ACC;
            end else if (if_req) begin
               bus_req_d   = 1'b1;
               bus_we_d    = 1'b0;
               bus_sel_d   = SEL_W'(ARB_SEL_ALL);
               bus_addr_d  = if_addr;
               bus_wdata_d = '0;
               last_dm_d   = 1'b0;
               state_d     = ARB_IF_ACC;
            end
         end

         ARB_IF_ACC, ARB_DM_ACC: begin
            if (bus_ack) begin
               bus_req_d = 1'b0;
               state_d   = ARB_DONE;
               if (state_q == ARB_IF_ACC) begin
                  if_ready_d = 1'b1;
                  if_rdata_d = bus_rdata;
               end else begin
                  dm_ready_d = 1'b1;
                  if (!bus_we_q) begin
                     dm_rdata_d = bus_rdata;
                  end
               end
            end
`ifdef ARB_TIMEOUT_EN
            else if (wd_expired) begin
               bus_req_d = 1'b0;
               bus_err_d = 1'b1;
               state_d   = ARB_DONE;
               if (state_q == ARB_IF_ACC) begin
                  if_ready_d = 1'b1;
                  if_rdata_d = '0;
               end else begin
                  dm_ready_d = 1'b1;
                  dm_rdata_d = '0;
               end
            end
`endif
         end

         ARB_DONE: begin
            // Requesters update their request during the ready cycle, so nothing is sampled here.
            state_d = ARB_IDLE;
         end

         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ARB_IDLE;
         last_dm_q   <= 1'b0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_sel_q   <= '0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         if_ready_q  <= 1'b0;
         dm_ready_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         bus_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         last_dm_q   <= last_dm_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_sel_q   <= bus_sel_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         if_ready_q  <= if_ready_d;
         dm_ready_q  <= dm_ready_d;
`ifdef ARB_TIMEOUT_EN
         bus_err_q   <= bus_err_d;
`endif
      end
   end

   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_sel   = bus_sel_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign if_ready  = if_ready_q;
   assign dm_ready  = dm_ready_q;

   // Stall requests feed the pipeline controller directly, hence combinational.
   assign stallreq_if  = if_req & ~if_ready_q;
   assign stallreq_mem = dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench; a transaction-level model queues expected bus
// transfers and ready pulses, a slave/monitor process checks them against the DUT.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = DW / 8;
`ifdef ARB_TIMEOUT_EN
   localparam int TO = 4;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic [DW-1:0] if_rdata;
   logic          if_ready;
   logic          dm_req = 1'b0;
   logic          dm_we = 1'b0;
   logic [SW-1:0] dm_sel = '0;
   logic [AW-1:0] dm_addr = '0;
   logic [DW-1:0] dm_wdata = '0;
   logic [DW-1:0] dm_rdata;
   logic          dm_ready;
   logic          bus_req, bus_we;
   logic [SW-1:0] bus_sel;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wdata;
   logic [DW-1:0] bus_rdata = '0;
   logic          bus_ack;
   logic          slave_ack = 1'b0;
   logic          spur_ack = 1'b0;
   logic          stallreq_if, stallreq_mem;
`ifdef ARB_TIMEOUT_EN
   logic          bus_err;
`endif

   assign bus_ack = slave_ack | spur_ack;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W (AW),
      .DATA_W (DW)
`ifdef ARB_TIMEOUT_EN
      ,
      .TIMEOUT(TO)
`endif
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .if_req       (if_req),
      .if_addr      (if_addr),
      .if_rdata     (if_rdata),
      .if_ready     (if_ready),
      .dm_req       (dm_req),
      .dm_we        (dm_we),
      .dm_sel       (dm_sel),
      .dm_addr      (dm_addr),
      .dm_wdata     (dm_wdata),
      .dm_rdata     (dm_rdata),
      .dm_ready     (dm_ready),
      .bus_req      (bus_req),
      .bus_we       (bus_we),
      .bus_sel      (bus_sel),
      .bus_addr     (bus_addr),
      .bus_wdata    (bus_wdata),
      .bus_rdata    (bus_rdata),
      .bus_ack      (bus_ack),
      .stallreq_if  (stallreq_if),
      .stallreq_mem (stallreq_mem)
`ifdef ARB_TIMEOUT_EN
      ,
      .bus_err      (bus_err)
`endif
   );

   typedef struct {
      bit            is_dm;
      logic          we;
      logic [SW-1:0] sel;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] brdata;
      logic [DW-1:0] exp_rdata;
      int            wt;
      int            start;   // -1: two cycles after the previous ready pulse
   } bus_t;

   typedef struct {
      bit            is_dm;
      logic [DW-1:0] rdata;
      int            cyc;
   } rdy_t;

   bus_t bq[$];
   rdy_t rq[$];

   int   vecs = 0;
   int   errs = 0;
   int   cyc = 0;
   bit   last_dm = 1'b0;
   logic [DW-1:0] dm_prev = '0;

   bus_t cur;
   bit   busy = 1'b0;
   int   wcnt = 0;
   int   last_rdy = 0;
   bit   due, due_dm;
   rdy_t r;

   function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
      end
   endfunction

   function automatic void fail_now(input string nm);
      vecs++;
      errs++;
      $display("FAIL %s: event did not occur (cycle %0d)", nm, cyc);
   endfunction

   function automatic bit timed_out(input int wt);
`ifdef ARB_TIMEOUT_EN
      return wt > TO;
`else
      return (wt < 0) ? 1'b0 : 1'b0;
`endif
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor + slave: checks ready pulses against the scoreboard, then plays the bus slave.
   always @(negedge clk) begin
      if (!rst) begin
         slave_ack = 1'b0;
         busy      = 1'b0;
      end else begin
         due    = (rq.size() > 0) && (rq[0].cyc == cyc);
         due_dm = due && rq[0].is_dm;
         chk("if_ready", if_ready, due && !due_dm);
         chk("dm_ready", dm_ready, due_dm);
         if (due) begin
            if (due_dm) chk("dm_rdata", dm_rdata, rq[0].rdata);
            else        chk("if_rdata", if_rdata, rq[0].rdata);
            void'(rq.pop_front());
         end
         chk("stallreq_if", stallreq_if, if_req && !(due && !due_dm));
         chk("stallreq_mem", stallreq_mem, dm_req && !due_dm);

         slave_ack = 1'b0;
         bus_rdata = $urandom;
         if (bus_req) begin
            if (!busy) begin
               if (bq.size() == 0) begin
                  fail_now("expected_bus_transfer");
                  cur.wt = -1;
               end else begin
                  cur = bq.pop_front();
                  chk("bus_start_cycle", 64'(cyc), 64'((cur.start < 0) ? last_rdy + 2 : cur.start));
               end
               busy = 1'b1;
               wcnt = 0;
            end
            chk("bus_we", bus_we, cur.we);
            chk("bus_sel", bus_sel, cur.sel);
            chk("bus_addr", bus_addr, cur.addr);
            if (cur.we) chk("bus_wdata", bus_wdata, cur.wdata);
            if (wcnt == cur.wt) begin
               slave_ack = 1'b1;
               bus_rdata = cur.brdata;
               r = '{is_dm: cur.is_dm, rdata: cur.exp_rdata, cyc: cyc + 1};
               rq.push_back(r);
               last_rdy = cyc + 1;
            end
`ifdef ARB_TIMEOUT_EN
            else if (wcnt == TO) begin
               r = '{is_dm: cur.is_dm, rdata: cur.exp_rdata, cyc: cyc + 1};
               rq.push_back(r);
               last_rdy = cyc + 1;
            end
`endif
            wcnt++;
         end else begin
            busy = 1'b0;
         end
      end
   end

   // Queues the expected transfers in arbitration order, then drives both requesters.
   task automatic run_pair(input bit do_if, input bit do_dm,
                           input logic [AW-1:0] ia, input logic [DW-1:0] ird, input int iwt,
                           input logic dwe, input logic [SW-1:0] dsel, input logic [AW-1:0] da,
                           input logic [DW-1:0] dwd, input logic [DW-1:0] drd, input int dwt,
                           input bit drop);
      bus_t e_if, e_dm;
      bit   dm_first, if_pend, dm_pend, got_if, got_dm, seen;
      int   n0;
      @(posedge clk); #1;
      n0   = cyc;
      e_if = '{is_dm: 1'b0, we: 1'b0, sel: SW'(ARB_SEL_ALL), addr: ia, wdata: '0,
               brdata: ird, exp_rdata: ird, wt: iwt, start: n0 + 1};
      e_dm = '{is_dm: 1'b1, we: dwe, sel: dsel, addr: da, wdata: dwd,
               brdata: drd, exp_rdata: '0, wt: dwt, start: n0 + 1};
      dm_first = do_dm && (!do_if || !last_dm);
      if (do_if && do_dm) begin
         if (dm_first) e_if.start = -1;
         else          e_dm.start = -1;
      end
      if (do_if && !dm_first) bq.push_back(e_if);
      if (do_dm) begin
         if (timed_out(dwt)) begin
            e_dm.exp_rdata = '0;
            dm_prev        = '0;
         end else if (dwe) begin
            e_dm.exp_rdata = dm_prev;
         end else begin
            e_dm.exp_rdata = drd;
            dm_prev        = drd;
         end
         bq.push_back(e_dm);
      end
      if (do_if && dm_first) bq.push_back(e_if);
      if (do_if && do_dm) last_dm = !dm_first;
      else if (do_dm)     last_dm = 1'b1;
      else if (do_if)     last_dm = 1'b0;

      if_req = do_if; if_addr = ia;
      dm_req = do_dm; dm_we = dwe; dm_sel = dsel; dm_addr = da; dm_wdata = dwd;
      if_pend = do_if;
      dm_pend = do_dm;
      for (int k = 0; k < 200 && (if_pend || dm_pend); k++) begin
         @(negedge clk);
         got_if = if_ready;
         got_dm = dm_ready;
         seen   = bus_req;
         @(posedge clk); #1;
         if (got_if) begin if_req = 1'b0; if_pend = 1'b0; end
         if (got_dm) begin dm_req = 1'b0; dm_pend = 1'b0; end
         if (drop && seen && dm_req) begin
            dm_req   = 1'b0;
            dm_addr  = $urandom;
            dm_wdata = $urandom;
            dm_we    = ~dm_we;
            dm_sel   = ~dm_sel;
         end
      end
      if (if_pend || dm_pend) begin
         fail_now("ready_handshake");
         if_req = 1'b0;
         dm_req = 1'b0;
      end
   endtask

   task automatic reset_mid();
      bit seen = 1'b0;
      @(posedge clk); #1;
      bq.push_back('{is_dm: 1'b1, we: 1'b0, sel: SW'(ARB_SEL_ALL), addr: 32'h200, wdata: '0,
                     brdata: 32'h1234_5678, exp_rdata: '0, wt: 6, start: cyc + 1});
      dm_req = 1'b1; dm_we = 1'b0; dm_sel = SW'(ARB_SEL_ALL); dm_addr = 32'h200;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         seen = bus_req;
      end
      if (!seen) fail_now("bus_req_before_reset");
      @(negedge clk); #2;
      rst = 1'b0;
      #1;
      chk("bus_req_async_reset", bus_req, 1'b0);
      chk("dm_ready_async_reset", dm_ready, 1'b0);
      dm_req  = 1'b0;
      last_dm = 1'b0;
      dm_prev = '0;
      @(posedge clk); #3;
      rst = 1'b1;
   endtask

   initial begin
      #12;
      chk("rst_bus_req", bus_req, 1'b0);
      chk("rst_bus_we", bus_we, 1'b0);
      chk("rst_bus_sel", bus_sel, '0);
      chk("rst_bus_addr", bus_addr, '0);
      chk("rst_bus_wdata", bus_wdata, '0);
      chk("rst_if_ready", if_ready, 1'b0);
      chk("rst_dm_ready", dm_ready, 1'b0);
      chk("rst_if_rdata", if_rdata, '0);
      chk("rst_dm_rdata", dm_rdata, '0);
`ifdef ARB_TIMEOUT_EN
      chk("rst_bus_err", bus_err, 1'b0);
`endif
      @(posedge clk); #3;
      rst = 1'b1;

      // Fetch alone with a zero-wait slave, then a two-wait-state store.
      run_pair(1'b1, 1'b0, 32'h40, 32'h3C01_0001, 0, 1'b0, '0, '0, '0, '0, 0, 1'b0);
      run_pair(1'b0, 1'b1, '0, '0, 0, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF, 32'h5555_AAAA, 2, 1'b0);
      run_pair(1'b0, 1'b1, '0, '0, 0, 1'b0, 4'b1111, 32'h104, '0, 32'hCAFE_F00D, 1, 1'b0);

      // Contention with a zero-wait slave: grants alternate.
      for (int i = 0; i < 3; i++)
         run_pair(1'b1, 1'b1, $urandom, $urandom, 0, 1'(i), 4'b1111, $urandom, $urandom, $urandom, 0, 1'b0);

      // Spurious acknowledge while idle.
      @(posedge clk); #1;
      spur_ack = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      spur_ack = 1'b0;
      chk("spurious_ack_bus_req", bus_req, 1'b0);

      // Request dropped and inputs changed mid-transaction.
      run_pair(1'b0, 1'b1, '0, '0, 0, 1'b1, 4'b0101, 32'h300, 32'h0BAD_CAFE, $urandom, 3, 1'b1);

      reset_mid();
      run_pair(1'b1, 1'b1, 32'h80, $urandom, 1, 1'b0, 4'b1100, 32'h208, '0, $urandom, 2, 1'b0);

      for (int i = 0; i < 40; i++) begin
         int mode;
         mode = int'($urandom_range(0, 2));
         run_pair(mode != 1, mode != 0, $urandom, $urandom, int'($urandom_range(0, 3)),
                  1'($urandom), SW'($urandom_range(1, 15)), $urandom, $urandom, $urandom,
                  int'($urandom_range(0, 3)), 1'b0);
      end

`ifdef ARB_TIMEOUT_EN
      chk("bus_err_before_timeout", bus_err, 1'b0);
      run_pair(1'b0, 1'b1, '0, '0, 0, 1'b0, 4'b1111, 32'h400, '0, 32'h7777_7777, 1000, 1'b0);
      chk("bus_err_after_timeout", bus_err, 1'b1);
      run_pair(1'b1, 1'b0, 32'h44, 32'h2402_0005, 1, 1'b0, '0, '0, '0, '0, 0, 1'b0);
      chk("bus_err_sticky", bus_err, 1'b1);
`endif

      repeat (6) @(posedge clk);
      #1;
      chk("bus_queue_drained", 64'(bq.size()), 64'd0);
      chk("ready_queue_drained", 64'(rq.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_time_limit: bench did not finish");
      $fatal(1);
   end

endmodule
